bcd_countdown: RTL and testbench

- Loadable multi-digit BCD down-counter (countdown timer); the counting-down complement of the team's decade up-counters.
- Decrements once per `en` tick while running, borrowing digit to digit.
- Stops at zero, or auto-reloads for periodic operation.
- Sits in the timer/clock datapath: `en` comes from the prescaler tick, `count` drives the 7-seg display mux, `done` feeds the alarm/beeper logic.

---
 rtl/bcd_countdown_if.sv | 24 ++
 rtl/bcd_countdown.sv | 129 ++++++++++++
 tb/tb_bcd_countdown.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_countdown_if.sv
// Control/status bundle between the timer datapath and a BCD countdown counter.
// The controller (prescaler, keypad logic) is the master; the counter is the slave.
interface bcd_countdown_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  done;

    modport master (
        output en, load, load_val, start, pause,
        input  count, busy, done
    );

    modport slave (
        input  en, load, load_val, start, pause,
        output count, busy, done
    );
endinterface

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD down-counter with one-shot or periodic (auto-reload) operation.
// Input priority: rst > load > pause > start > en; all outputs come straight from registers.
module bcd_countdown #(
    parameter int DIGITS = 4,
    parameter bit RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    bcd_countdown_if.slave   cd_if
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   dec_val;

    // Clamp every nibble above 9 down to 9 so the stored value is always valid BCD.
    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Borrow enters digit 0 and ripples upward through every digit sitting at 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign dec_val = bcd_dec(count_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;

        if (cd_if.load) begin
            count_d  = bcd_sat(cd_if.load_val);
            shadow_d = bcd_sat(cd_if.load_val);
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cd_if.start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cd_if.pause) begin
                        state_d = PAUSE;
                    end else if (cd_if.en) begin
                        if (dec_val == '0) begin
                            // Terminal count: zero is shown only when the run actually stops.
                            done_d = 1'b1;
                            if (RELOAD && (shadow_q != '0)) begin
                                count_d = shadow_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = dec_val;
                        end
                    end
                end
                PAUSE: begin
                    if (cd_if.start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cd_if.count = count_q;
    assign cd_if.busy  = busy_q;
    assign cd_if.done  = done_q;
endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench for bcd_countdown: a one-shot and a periodic instance share the same stimulus.
module tb_bcd_countdown;
    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_countdown_if #(.DIGITS(4)) if0 ();
    bcd_countdown_if #(.DIGITS(4)) if1 ();

    bcd_countdown #(.DIGITS(4), .RELOAD(1'b0)) u_oneshot (.clk(clk), .rst(rst), .cd_if(if0));
    bcd_countdown #(.DIGITS(4), .RELOAD(1'b1)) u_periodic (.clk(clk), .rst(rst), .cd_if(if1));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        load;
        logic        start;
        logic        pause;
        logic [15:0] lv;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
    } step_t;

    typedef struct {
        logic [15:0] cnt;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t  sbq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic step_t mk(input logic r, e, l, s, p, input logic [15:0] lv,
                                 input logic [15:0] cnt, input logic busy, done);
        step_t t;
        t.rst = r; t.en = e; t.load = l; t.start = s; t.pause = p; t.lv = lv;
        t.cnt = cnt; t.busy = busy; t.done = done;
        return t;
    endfunction

    // Apply one cycle of stimulus to both instances; outputs are sampled 1 time unit after the edge.
    task automatic tick(input step_t t);
        rst = t.rst;
        if0.en = t.en; if0.load = t.load; if0.start = t.start; if0.pause = t.pause; if0.load_val = t.lv;
        if1.en = t.en; if1.load = t.load; if1.start = t.start; if1.pause = t.pause; if1.load_val = t.lv;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if0.en = 1'b0; if0.load = 1'b0; if0.start = 1'b0; if0.pause = 1'b0;
        if1.en = 1'b0; if1.load = 1'b0; if1.start = 1'b0; if1.pause = 1'b0;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL reset[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_borrow();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h1000, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0999, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0998, 1, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL borrow[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_oneshot();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0003, 16'h0003, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_pause();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0050, 16'h0050, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0050, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0049, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0048, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0048, 1, 0));
        for (int k = 0; k < 5; k++)
            s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0048, 1, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0048, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0047, 1, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL pause[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_periodic();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0));
            s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 1));
        end
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if1.count !== e.cnt || if1.busy !== e.busy || if1.done !== e.done) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if1.count, if1.busy, if1.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_abort();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0F3A, 16'h0939, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0939, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0938, 1, 0));
        s.push_back(mk(0, 1, 1, 0, 0, 16'h0005, 16'h0005, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0005, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0004, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL abort[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0));
        s.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 16'h0001, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0010, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0009, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0009, 1, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 16'h0200, 16'h0200, 0, 0));
        foreach (s[i]) begin
            sbq.push_back('{s[i].cnt, s[i].busy, s[i].done});
            tick(s[i]);
            e = sbq.pop_front();
            n_checks++;
            if (if0.count !== e.cnt || if0.busy !== e.busy || if0.done !== e.done) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got count=%h busy=%b done=%b, want count=%h busy=%b done=%b",
                         i, if0.count, if0.busy, if0.done, e.cnt, e.busy, e.done);
            end
        end
    endtask

    initial begin
        if0.en = 1'b0; if0.load = 1'b0; if0.start = 1'b0; if0.pause = 1'b0; if0.load_val = '0;
        if1.en = 1'b0; if1.load = 1'b0; if1.start = 1'b0; if1.pause = 1'b0; if1.load_val = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_borrow();
        test_oneshot();
        test_pause();
        test_periodic();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
